// File: rtl/label_neighbor_buffer.sv
// label_neighbor_buffer
//   Streams raster-order pixel labels and presents, with zero latency, the
//   labels of the left neighbour (col-1,row) and the top neighbour (col,row-1)
//   of the pixel currently on the input. A one-row line buffer holds the
//   previous row. A left register holds the previous pixel. col/row counters
//   track the raster position. Label values are stored and returned untouched.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   pixel_valid    in   current pixel presented, accepted at next rising edge
//   sof            in   start of frame (qualified by pixel_valid), forces (0,0)
//   current_label  in   final label of current pixel (0 = background)
//   left_label     out  label at (col-1,row), 0 at col 0 or when idle
//   top_label      out  label at (col,row-1), 0 at row 0 or when idle
//   col, row       out  effective position of the current pixel
//   last_in_row    out  current pixel is the last of its row
//   last_in_frame  out  current pixel is the last of the frame
module label_neighbor_buffer #(
    parameter int LABEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pixel_valid,
    input  logic                          sof,
    input  logic [LABEL_WIDTH-1:0]        current_label,
    output logic [LABEL_WIDTH-1:0]        left_label,
    output logic [LABEL_WIDTH-1:0]        top_label,
    output logic [$clog2(IMG_WIDTH)-1:0]  col,
    output logic [$clog2(IMG_HEIGHT)-1:0] row,
    output logic                          last_in_row,
    output logic                          last_in_frame
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]          col_r;
    logic [RW-1:0]          row_r;
    logic [LABEL_WIDTH-1:0] left_r;
    // Deliberately unreset: row 0 forces top_label to 0, so stale contents
    // from an earlier frame can never be observed.
    logic [LABEL_WIDTH-1:0] line_buf_r [IMG_WIDTH];

    logic [CW-1:0] eff_col_s;
    logic [RW-1:0] eff_row_s;
    logic          at_last_col_s;
    logic          at_last_row_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic          accept_s;

    // Effective position: sof on a valid pixel overrides the counters.
    always_comb begin
        accept_s = pixel_valid;
        if (pixel_valid && sof) begin
            eff_col_s = {CW{1'b0}};
            eff_row_s = {RW{1'b0}};
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
        at_last_col_s = (eff_col_s == COL_LAST);
        at_last_row_s = (eff_row_s == ROW_LAST);
    end

    // Neighbour outputs; all forced to 0 while no pixel is presented.
    always_comb begin
        col = eff_col_s;
        row = eff_row_s;
        if (pixel_valid) begin
            if (eff_col_s == {CW{1'b0}}) begin
                left_label = {LABEL_WIDTH{1'b0}};
            end else begin
                left_label = left_r;
            end
            if (eff_row_s == {RW{1'b0}}) begin
                top_label = {LABEL_WIDTH{1'b0}};
            end else begin
                top_label = line_buf_r[eff_col_s];
            end
            last_in_row   = at_last_col_s;
            last_in_frame = at_last_col_s && at_last_row_s;
        end else begin
            left_label    = {LABEL_WIDTH{1'b0}};
            top_label     = {LABEL_WIDTH{1'b0}};
            last_in_row   = 1'b0;
            last_in_frame = 1'b0;
        end
    end

    // Next raster position after an accepted pixel.
    always_comb begin
        if (!at_last_col_s) begin
            col_nxt_s = eff_col_s + CW'(1'b1);
            row_nxt_s = eff_row_s;
        end else if (!at_last_row_s) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = eff_row_s + RW'(1'b1);
        end else begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = {RW{1'b0}};
        end
    end

    // Position counters and left register; only accepted pixels move state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
            left_r <= {LABEL_WIDTH{1'b0}};
        end else if (accept_s) begin
            col_r  <= col_nxt_s;
            row_r  <= row_nxt_s;
            left_r <= current_label;
        end else begin
            col_r  <= col_r;
            row_r  <= row_r;
            left_r <= left_r;
        end
    end

    // Line buffer write; the read above sees the pre-write value.
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            line_buf_r[eff_col_s] <= current_label;
        end
    end

endmodule

// File: tb/tb_label_neighbor_buffer.sv
module tb_label_neighbor_buffer;

    localparam int LW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pixel_valid;
    logic          sof;
    logic [LW-1:0] current_label;
    logic [LW-1:0] left_label;
    logic [LW-1:0] top_label;
    logic [1:0]    col;
    logic [1:0]    row;
    logic          last_in_row;
    logic          last_in_frame;

    label_neighbor_buffer #(.LABEL_WIDTH(LW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .sof(sof),
        .current_label(current_label), .left_label(left_label),
        .top_label(top_label), .col(col), .row(row),
        .last_in_row(last_in_row), .last_in_frame(last_in_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          s;
        logic [LW-1:0] cur;
        logic [LW-1:0] left;
        logic [LW-1:0] top;
        int            c;
        int            r;
        logic          lir;
        logic          lif;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic v, input logic s, input int cur,
                                input int l, input int t, input int c, input int r,
                                input logic lir, input logic lif);
        vec_t e;
        e.v = v; e.s = s; e.cur = LW'(cur); e.left = LW'(l); e.top = LW'(t);
        e.c = c; e.r = r; e.lir = lir; e.lif = lif;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Pop the expected record and compare every output against it.
    task automatic compare(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            check("left_label",    idx, int'(left_label),    int'(e.left));
            check("top_label",     idx, int'(top_label),     int'(e.top));
            check("col",           idx, int'(col),           e.c);
            check("row",           idx, int'(row),           e.r);
            check("last_in_row",   idx, int'(last_in_row),   int'(e.lir));
            check("last_in_frame", idx, int'(last_in_frame), int'(e.lif));
        end
    endtask

    // Drive one vector just after a rising edge, check at the falling edge.
    task automatic step(input vec_t e, input int idx);
        pixel_valid   = e.v;
        sof           = e.s;
        current_label = e.cur;
        sb.push_back(e);
        @(negedge clk);
        compare(idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; pixel_valid = 1'b1; sof = 1'b0; current_label = 8'd9;

        // Row 0: 5,0,5,7
        add(1, 1,  5,  0, 0, 0, 0, 0, 0);
        add(1, 0,  0,  5, 0, 1, 0, 0, 0);
        add(1, 0,  5,  0, 0, 2, 0, 0, 0);
        add(1, 0,  7,  5, 0, 3, 0, 1, 0);
        // Row 1: 5,5,0,7 with a 3-cycle stall after the first pixel
        add(1, 0,  5,  0, 5, 0, 1, 0, 0);
        add(0, 0,  3,  0, 0, 1, 1, 0, 0);
        add(0, 1,  3,  0, 0, 1, 1, 0, 0);
        add(0, 0,  3,  0, 0, 1, 1, 0, 0);
        add(1, 0,  5,  5, 0, 1, 1, 0, 0);
        add(1, 0,  0,  5, 5, 2, 1, 0, 0);
        add(1, 0,  7,  0, 7, 3, 1, 1, 0);
        // Row 2: 1,2,3,4; last pixel ends the frame
        add(1, 0,  1,  0, 5, 0, 2, 0, 0);
        add(1, 0,  2,  1, 5, 1, 2, 0, 0);
        add(1, 0,  3,  2, 0, 2, 2, 0, 0);
        add(1, 0,  4,  3, 7, 3, 2, 1, 1);
        // Wrap to (0,0) without sof: stale buffer must not show on top
        add(1, 0,  6,  0, 0, 0, 0, 0, 0);
        add(1, 0,  8,  6, 0, 1, 0, 0, 0);
        add(1, 0,  9,  8, 0, 2, 0, 0, 0);
        add(1, 0, 10,  9, 0, 3, 0, 1, 0);
        add(1, 0, 11,  0, 6, 0, 1, 0, 0);
        add(1, 0, 12, 11, 8, 1, 1, 0, 0);
        // sof at (2,1) restarts the frame
        add(1, 1, 13,  0, 0, 0, 0, 0, 0);
        add(1, 0, 14, 13, 0, 1, 0, 0, 0);
        add(1, 0, 15, 14, 0, 2, 0, 0, 0);
        add(1, 0, 16, 15, 0, 3, 0, 1, 0);
        add(1, 0, 17,  0, 13, 0, 1, 0, 0);
        add(1, 0, 18, 17, 14, 1, 1, 0, 0);
        add(1, 0, 19, 18, 15, 2, 1, 0, 0);
        add(1, 0, 20, 19, 16, 3, 1, 1, 0);
        add(1, 0, 21,  0, 17, 0, 2, 0, 0);

        // Reset state with a valid pixel held on the input
        repeat (2) @(posedge clk);
        #1;
        e = '{v:1'b1, s:1'b0, cur:8'd9, left:8'd0, top:8'd0, c:0, r:0, lir:1'b0, lif:1'b0};
        sb.push_back(e);
        @(negedge clk);
        compare(-1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Now at (1,2): asynchronous reset mid-frame
        pixel_valid = 1'b1; sof = 1'b0; current_label = 8'd22;
        rst = 1'b1;
        e = '{v:1'b1, s:1'b0, cur:8'd22, left:8'd0, top:8'd0, c:0, r:0, lir:1'b0, lif:1'b0};
        sb.push_back(e);
        @(negedge clk);
        compare(100);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e = '{v:1'b1, s:1'b0, cur:8'd23, left:8'd0, top:8'd0, c:0, r:0, lir:1'b0, lif:1'b0};
        step(e, 101);
        e = '{v:1'b1, s:1'b0, cur:8'd24, left:8'd23, top:8'd0, c:1, r:0, lir:1'b0, lif:1'b0};
        step(e, 102);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/label_neighbor_buffer.md
LABEL_NEIGHBOR_BUFFER -- requirements
Module: label_neighbor_buffer

Interface
REQ-001 Parameter LABEL_WIDTH, default 8, width of every label port and line-buffer entry.
REQ-002 Parameter IMG_WIDTH, default 320, pixels per row (>=2).
REQ-003 Parameter IMG_HEIGHT, default 240, rows per frame (>=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pixel_valid  input  1  current pixel is presented this cycle and is accepted at the next rising edge.
REQ-007 sof  input  1  start of frame; qualified by pixel_valid, marks the current pixel as (0,0).
REQ-008 current_label  input  LABEL_WIDTH  final label of the current pixel, returned by the downstream labeler in the same cycle; 0 = background.
REQ-009 left_label  output  LABEL_WIDTH  label of the pixel at (col-1,row); 0 at col 0.
REQ-010 top_label  output  LABEL_WIDTH  label of the pixel at (col,row-1); 0 at row 0.
REQ-011 col  output  clog2(IMG_WIDTH)  column of the current pixel.
REQ-012 row  output  clog2(IMG_HEIGHT)  row of the current pixel.
REQ-013 last_in_row  output  1  current pixel is the last pixel of its row.
REQ-014 last_in_frame  output  1  current pixel is the last pixel of the frame.

Function
REQ-015 The block SHALL hold a line buffer of IMG_WIDTH entries of LABEL_WIDTH bits plus a left register (LABEL_WIDTH) and col/row counters.
REQ-016 left_label, top_label, last_in_row and last_in_frame SHALL be combinational from state and inputs, with zero latency relative to the pixel they describe.
REQ-017 When pixel_valid=0 the block SHALL drive left_label=0, top_label=0, last_in_row=0 and last_in_frame=0, and no state SHALL change.
REQ-018 Effective position: if pixel_valid && sof, then (0,0); otherwise (col,row) from the counters; col/row outputs SHALL show the effective position.
REQ-019 left_label SHALL be 0 when effective col=0, otherwise the left register.
REQ-020 top_label SHALL be 0 when effective row=0, otherwise line_buf[effective col] as held before this cycle's write (read-before-write).
REQ-021 On an accepted pixel the block SHALL write current_label to line_buf[effective col] and load current_label into the left register.
REQ-022 On an accepted pixel with col<IMG_WIDTH-1 the block SHALL increment col and leave row unchanged.
REQ-023 On an accepted pixel at col=IMG_WIDTH-1 (last_in_row=1) the block SHALL set col=0 and increment row.
REQ-024 On an accepted pixel at (IMG_WIDTH-1,IMG_HEIGHT-1) (last_in_frame=1) the block SHALL set col=0 and row=0.
REQ-025 last_in_row SHALL equal pixel_valid && effective col==IMG_WIDTH-1; last_in_frame SHALL equal last_in_row && effective row==IMG_HEIGHT-1.
REQ-026 sof on any pixel SHALL restart the frame at (0,0) with no error; the counters then advance from (0,0) per REQ-022 to REQ-024.
REQ-027 Line-buffer contents left from a previous frame SHALL never reach top_label, because row 0 forces top_label=0.
REQ-028 The block SHALL NOT interpret or resolve label values; equivalence merging is owned downstream.
REQ-029 The left register and line buffer SHALL tolerate current_label=0 and store it unchanged.

Reset
REQ-030 While rst=1: col=0, row=0, left register=0, and all outputs SHALL be 0.
REQ-031 Line-buffer contents SHALL NOT be reset; REQ-027 guarantees correctness.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the first accepted pixel after release SHALL be (0,0).

Verification (W=4, H=3, LABEL_WIDTH=8)
REQ-033 Row 0: feed current_label 5,0,5,7 -> left_label 0,5,0,5 and top_label 0,0,0,0; last_in_row=1 only on the 4th pixel; then row=1, col=0.
REQ-034 Row 1 after REQ-033: feed 5,5,0,7 -> top_label 5,0,5,7 and left_label 0,5,5,0 (col 0 forced 0).
REQ-035 Stall: insert 3 idle cycles between pixels -> outputs 0 while idle; col/row and labels resume unchanged.
REQ-036 Pixel 12 at (3,2) -> last_in_frame=1; next pixel is (0,0) with top_label=0 even though the line buffer is non-zero.
REQ-037 sof asserted at (2,1) -> col=0, row=0, top_label=0, left_label=0 that cycle; next pixel is (1,0).
REQ-038 rst pulse at (1,2) -> outputs 0 during reset; first pixel after release is (0,0) with left_label=0 and top_label=0.
